mat_accum_drain: RTL and testbench
==================================

MAT_ACCUM_DRAIN -- requirements
Module: mat_accum_drain

Interface
REQ-001 Parameter DATA_LEN, 32, element width in bits.
REQ-002 Parameter M, 8, rows of partial-product matrix.
REQ-003 Parameter N, 8, columns of partial-product matrix.
REQ-004 Parameter K, 8, partial products accumulated per result matrix.
REQ-005 i_clk  input  1  clock; all state SHALL update on rising edge.
REQ-006 i_rstn  input  1  reset, asynchronous, active-low.
REQ-007 i_clear  input  1  synchronous abort: discard accumulation and drain.
REQ-008 i_mat_valid  input  1  partial-product matrix valid.
REQ-009 o_mat_ready  output  1  block accepts partial-product matrix.
REQ-010 i_mat_p  input  DATA_LEN*M*N  signed partial matrix; element (r,c) at bit offset DATA_LEN*(N*r+c).
REQ-011 o_row_valid  output  1  result row valid.
REQ-012 i_row_ready  input  1  downstream accepts row.
REQ-013 o_row_data  output  DATA_LEN*N  signed result row; column c at bit offset DATA_LEN*c.
REQ-014 o_row_idx  output  clog2(M)  index of the row on o_row_data.
REQ-015 o_row_last  output  1  high with row M-1.

Function
REQ-016 Input handshake SHALL occur on a cycle with i_mat_valid=1 and o_mat_ready=1; output handshake SHALL occur on a cycle with o_row_valid=1 and i_row_ready=1.
REQ-017 FSM SHALL have two states: ACCUM (o_mat_ready=1, o_row_valid=0) and DRAIN (o_mat_ready=0, o_row_valid=1).
REQ-018 In ACCUM, beat counter SHALL count input handshakes 0..K-1.
REQ-019 On a handshake with count=0, accumulator SHALL load i_mat_p; with count>0, accumulator SHALL add i_mat_p element-wise.
REQ-020 Element sums SHALL be DATA_LEN-bit two's-complement with wrap-around, no saturation, no overflow flag.
REQ-021 The handshake at count=K-1 SHALL move the FSM to DRAIN, reset the counter to 0, and set row index to 0.
REQ-022 Latency: the K-th input handshake at cycle t SHALL yield o_row_valid=1 with row 0 at cycle t+1.
REQ-023 In DRAIN, o_row_data SHALL show accumulator row o_row_idx, registered or muxed from registered state, and SHALL stay stable while i_row_ready=0.
REQ-024 Each output handshake SHALL increment o_row_idx.
REQ-025 A handshake with o_row_last=1 SHALL return the FSM to ACCUM, set o_mat_ready=1 next cycle, and reset row index to 0.
REQ-026 Backpressure: i_row_ready held low SHALL hold DRAIN indefinitely with no data loss.
REQ-027 i_mat_valid while in DRAIN SHALL be ignored; the accumulator SHALL NOT change.
REQ-028 i_clear=1 in any state SHALL force ACCUM with counter and row index at 0 next cycle, and SHALL override a coincident input or output handshake; that beat or row is discarded.
REQ-029 K=1 SHALL be legal: every accepted matrix drains directly.

Reset
REQ-030 Asserting i_rstn low SHALL immediately force ACCUM, counter 0, row index 0, accumulator 0.
REQ-031 Reset values: o_mat_ready=0 during reset and 1 from the first edge after release; o_row_valid=0, o_row_idx=0, o_row_last=0, o_row_data=0.
REQ-032 Reset mid-accumulation or mid-drain SHALL discard all partial results; no row of the aborted matrix SHALL appear afterward.

Structure
REQ-033 A shared package SHALL hold the DATA_LEN/M/N/K defaults, the flat-matrix offset function (row, col) -> bit offset, and the FSM state encoding, shared with the partial-product generator.
REQ-034 One sub-module SHALL be natural: mat_row_acc, an N-lane DATA_LEN wrap-around adder with load/add select, instantiated M times.

Verification
REQ-035 Identity accumulate: K=8 beats, each all elements=1 with no stalls -> 8 rows, every element=8, idx 0..7, o_row_last on idx 7, row 0 at cycle after 8th beat.
REQ-036 Wrap: beat0 element(0,0)=0x7FFFFFFF, beat1 element(0,0)=1, rest 0 -> row 0 col 0 = 0x80000000.
REQ-037 Signed mix: element(3,5)=-3 on all 8 beats -> row 3 col 5 = -24 (0xFFFFFFE8); all other elements 0.
REQ-038 Backpressure: i_row_ready low 5 cycles during row 2 -> o_row_data and idx 2 stable; i_mat_valid pulsed in DRAIN -> no o_mat_ready, next result unaffected.
REQ-039 Clear: i_clear at count=4 coincident with a valid beat -> ready stays high, next 8 beats of value 2 drain as 16 everywhere.
REQ-040 Reset mid-drain at row 3 -> outputs zero immediately; next 8 beats of value 1 drain as all-8 starting at idx 0.

Source files
------------

// File: rtl/mat_accum_drain_pkg.sv
// Shared definitions for the partial-product accumulator and its generator:
// default geometry, flat-matrix element offsets and the FSM state encoding.
package mat_accum_drain_pkg;

  localparam int DATA_LEN_DEF = 32;
  localparam int M_DEF        = 8;
  localparam int N_DEF        = 8;
  localparam int K_DEF        = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } acc_state_t;

  // Bit offset of element (row, col) inside a row-major flattened matrix.
  function automatic int mat_offset(input int row, input int col,
                                    input int n_cols, input int data_len);
    return data_len * (n_cols * row + col);
  endfunction

endpackage

// File: rtl/mat_accum_drain_row.sv
// One accumulator row: N independent DATA_LEN-bit wrap-around lanes.
module mat_row_acc #(
  parameter int DATA_LEN = 32,
  parameter int N        = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [N*DATA_LEN-1:0] i_row,
  output logic [N*DATA_LEN-1:0] o_row
);

  // Two's-complement sum truncated to the lane width; overflow simply wraps.
  function automatic logic signed [DATA_LEN-1:0] wrap_add(
    input logic signed [DATA_LEN-1:0] a,
    input logic signed [DATA_LEN-1:0] b
  );
    return a + b;
  endfunction

  for (genvar c = 0; c < N; c++) begin : g_lane
    logic signed [DATA_LEN-1:0] in_lane;
    logic signed [DATA_LEN-1:0] lane_p0;

    assign in_lane = $signed(i_row[c*DATA_LEN +: DATA_LEN]);

    // p0: lane accumulator register
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        lane_p0 <= '0;
      end else if (i_en) begin
        lane_p0 <= i_load ? in_lane : wrap_add(lane_p0, in_lane);
      end
    end

    assign o_row[c*DATA_LEN +: DATA_LEN] = lane_p0;
  end

endmodule

// File: rtl/mat_accum_drain.sv
// Accumulates K partial-product matrices element-wise, then streams the
// M result rows out one per output handshake before accepting new input.
module mat_accum_drain
  import mat_accum_drain_pkg::*;
#(
  parameter  int DATA_LEN = DATA_LEN_DEF,
  parameter  int M        = M_DEF,
  parameter  int N        = N_DEF,
  parameter  int K        = K_DEF,
  localparam int IDX_W    = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_clear,
  input  logic                    i_mat_valid,
  output logic                    o_mat_ready,
  input  logic [DATA_LEN*M*N-1:0] i_mat_p,
  output logic                    o_row_valid,
  input  logic                    i_row_ready,
  output logic [DATA_LEN*N-1:0]   o_row_data,
  output logic [IDX_W-1:0]        o_row_idx,
  output logic                    o_row_last
);

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  acc_state_t          state_p0, state_nxt;
  logic [CNT_W-1:0]    cnt_p0, cnt_nxt;
  logic [IDX_W-1:0]    idx_p0, idx_nxt;
  logic                live_p0;
  logic                in_hs, out_hs, acc_en, acc_load;
  logic [N*DATA_LEN-1:0] acc_row [M];

  assign o_mat_ready = live_p0 && (state_p0 == ST_ACCUM);
  assign o_row_valid = (state_p0 == ST_DRAIN);
  assign o_row_idx   = idx_p0;
  assign o_row_last  = o_row_valid && (idx_p0 == IDX_W'(M - 1));
  assign o_row_data  = acc_row[idx_p0];

  assign in_hs    = i_mat_valid && o_mat_ready;
  assign out_hs   = o_row_valid && i_row_ready;
  assign acc_en   = in_hs && !i_clear;
  assign acc_load = (cnt_p0 == '0);

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    idx_nxt   = idx_p0;
    if (i_clear) begin
      state_nxt = ST_ACCUM;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      unique case (state_p0)
        ST_ACCUM: begin
          if (in_hs) begin
            if (cnt_p0 == CNT_W'(K - 1)) begin
              state_nxt = ST_DRAIN;
              cnt_nxt   = '0;
              idx_nxt   = '0;
            end else begin
              cnt_nxt = cnt_p0 + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (out_hs) begin
            if (idx_p0 == IDX_W'(M - 1)) begin
              state_nxt = ST_ACCUM;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx_p0 + 1'b1;
            end
          end
        end
        default: state_nxt = ST_ACCUM;
      endcase
    end
  end

  // p0: control state; live_p0 keeps ready low until the first edge after reset
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_p0 <= ST_ACCUM;
      cnt_p0   <= '0;
      idx_p0   <= '0;
      live_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      idx_p0   <= idx_nxt;
      live_p0  <= 1'b1;
    end
  end

  for (genvar r = 0; r < M; r++) begin : g_row
    mat_row_acc #(
      .DATA_LEN (DATA_LEN),
      .N        (N)
    ) u_row_acc (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_en   (acc_en),
      .i_load (acc_load),
      .i_row  (i_mat_p[mat_offset(r, 0, N, DATA_LEN) +: N*DATA_LEN]),
      .o_row  (acc_row[r])
    );
  end

endmodule

// File: tb/tb_mat_accum_drain.sv
// Directed and randomized checks of mat_accum_drain against a beat-list
// reference model that sums every accepted matrix at drain time.
module tb_mat_accum_drain;

  localparam int DL = 32;
  localparam int MM = 8;
  localparam int NN = 8;
  localparam int KK = 8;

  typedef logic [DL*MM*NN-1:0] mat_t;
  typedef logic [DL*NN-1:0]    row_t;

  logic           i_clk = 1'b0;
  logic           i_rstn;
  logic           i_clear;
  logic           i_mat_valid;
  logic           o_mat_ready;
  mat_t           i_mat_p;
  logic           o_row_valid;
  logic           i_row_ready;
  row_t           o_row_data;
  logic [2:0]     o_row_idx;
  logic           o_row_last;

  int total = 0;
  int bad   = 0;
  mat_t beats[$];

  mat_accum_drain dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_clear     (i_clear),
    .i_mat_valid (i_mat_valid),
    .o_mat_ready (o_mat_ready),
    .i_mat_p     (i_mat_p),
    .o_row_valid (o_row_valid),
    .i_row_ready (i_row_ready),
    .o_row_data  (o_row_data),
    .o_row_idx   (o_row_idx),
    .o_row_last  (o_row_last)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat_t fill(input logic [DL-1:0] v);
    mat_t m;
    for (int i = 0; i < MM*NN; i++) m[DL*i +: DL] = v;
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < MM*NN; i++) m[DL*i +: DL] = $urandom;
    return m;
  endfunction

  // Expected row r: element-wise sum of every accepted beat, modulo 2^32.
  function automatic row_t exp_row(input int r);
    row_t res;
    for (int c = 0; c < NN; c++) begin
      logic [DL-1:0] s;
      s = '0;
      foreach (beats[b]) s = s + beats[b][DL*(NN*r + c) +: DL];
      res[DL*c +: DL] = s;
    end
    return res;
  endfunction

  task automatic beat(input mat_t m);
    @(negedge i_clk);
    chk("mat_ready_accum", o_mat_ready, 1'b1);
    chk("row_valid_accum", o_row_valid, 1'b0);
    i_mat_valid = 1'b1;
    i_mat_p     = m;
    @(posedge i_clk);
    #1 i_mat_valid = 1'b0;
    beats.push_back(m);
  endtask

  task automatic drain_rows(input int nrows, input int stall_row, input int stall_cyc);
    row_t e;
    for (int r = 0; r < nrows; r++) begin
      @(negedge i_clk);
      e = exp_row(r);
      chk("row_valid", o_row_valid, 1'b1);
      chk("row_idx", o_row_idx, r[2:0]);
      chk("row_last", o_row_last, (r == MM-1));
      chk("row_data", o_row_data, e);
      chk("mat_ready_drain", o_mat_ready, 1'b0);
      if (r == stall_row) begin
        i_row_ready = 1'b0;
        i_mat_valid = 1'b1;
        for (int s = 0; s < stall_cyc; s++) begin
          i_mat_p = rand_mat();
          @(negedge i_clk);
          chk("stall_data", o_row_data, e);
          chk("stall_idx", o_row_idx, r[2:0]);
          chk("stall_valid", o_row_valid, 1'b1);
          chk("stall_mat_ready", o_mat_ready, 1'b0);
        end
        i_mat_valid = 1'b0;
      end
      i_row_ready = 1'b1;
      @(posedge i_clk);
      #1 i_row_ready = 1'b0;
    end
    if (nrows == MM) begin
      beats.delete();
      @(negedge i_clk);
      chk("post_drain_ready", o_mat_ready, 1'b1);
      chk("post_drain_valid", o_row_valid, 1'b0);
      chk("post_drain_idx", o_row_idx, 3'd0);
    end
  endtask

  initial begin
    mat_t m;
    i_rstn      = 1'b0;
    i_clear     = 1'b0;
    i_mat_valid = 1'b0;
    i_row_ready = 1'b0;
    i_mat_p     = '0;
    #1;
    chk("rst_mat_ready", o_mat_ready, 1'b0);
    chk("rst_row_valid", o_row_valid, 1'b0);
    chk("rst_row_idx", o_row_idx, 3'd0);
    chk("rst_row_last", o_row_last, 1'b0);
    chk("rst_row_data", o_row_data, '0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;

    // Identity accumulate: eight all-ones beats give eights everywhere.
    for (int b = 0; b < KK; b++) beat(fill(32'd1));
    drain_rows(MM, -1, 0);

    // Wrap-around at element (0,0).
    m = '0; m[31:0] = 32'h7FFF_FFFF; beat(m);
    m = '0; m[31:0] = 32'h0000_0001; beat(m);
    for (int b = 2; b < KK; b++) beat('0);
    #2 chk("wrap_r0c0", o_row_data[31:0], 32'h8000_0000);
    drain_rows(MM, -1, 0);

    // Signed mix at element (3,5).
    m = '0; m[DL*(NN*3 + 5) +: DL] = 32'hFFFF_FFFD;
    for (int b = 0; b < KK; b++) beat(m);
    drain_rows(MM, -1, 0);

    // Backpressure on row 2 with input pulses during drain.
    for (int b = 0; b < KK; b++) beat(rand_mat());
    drain_rows(MM, 2, 5);
    for (int b = 0; b < KK; b++) beat(rand_mat());
    drain_rows(MM, -1, 0);

    // Clear at count 4 coincident with a valid beat.
    for (int b = 0; b < 4; b++) beat(rand_mat());
    @(negedge i_clk);
    i_clear = 1'b1; i_mat_valid = 1'b1; i_mat_p = rand_mat();
    @(posedge i_clk);
    #1 i_clear = 1'b0; i_mat_valid = 1'b0;
    beats.delete();
    for (int b = 0; b < KK; b++) beat(fill(32'd2));
    drain_rows(MM, -1, 0);

    // Clear during drain coincident with an output handshake.
    for (int b = 0; b < KK; b++) beat(rand_mat());
    drain_rows(2, -1, 0);
    @(negedge i_clk);
    i_clear = 1'b1; i_row_ready = 1'b1;
    @(posedge i_clk);
    #1 i_clear = 1'b0; i_row_ready = 1'b0;
    beats.delete();
    @(negedge i_clk);
    chk("clr_drain_valid", o_row_valid, 1'b0);
    chk("clr_drain_ready", o_mat_ready, 1'b1);
    chk("clr_drain_idx", o_row_idx, 3'd0);

    // Reset mid-drain at row 3.
    for (int b = 0; b < KK; b++) beat(rand_mat());
    drain_rows(3, -1, 0);
    @(negedge i_clk);
    chk("pre_rst_idx", o_row_idx, 3'd3);
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_valid", o_row_valid, 1'b0);
    chk("mid_rst_ready", o_mat_ready, 1'b0);
    chk("mid_rst_idx", o_row_idx, 3'd0);
    chk("mid_rst_last", o_row_last, 1'b0);
    chk("mid_rst_data", o_row_data, '0);
    beats.delete();
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    for (int b = 0; b < KK; b++) beat(fill(32'd1));
    drain_rows(MM, -1, 0);

    // Randomized rounds with a random stalled row.
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < KK; b++) beat(rand_mat());
      drain_rows(MM, $urandom_range(MM-1, 0), $urandom_range(4, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
